// File: rtl/iob_fifo_stream_ctrl.sv
// Stream FIFO controller for an external 1R1W RAM with a 2-entry prefetch buffer (FWFT output).
// Push-to-m_valid latency 3 cycles; s_ready_o drops only when the RAM is full, reads stall when the buffer is committed.
module iob_fifo_stream_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              clear_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic [ADDR_W:0]   level_o,
  output logic              ext_mem_w_en_o,
  output logic [ADDR_W-1:0] ext_mem_w_addr_o,
  output logic [DATA_W-1:0] ext_mem_w_data_o,
  output logic              ext_mem_r_en_o,
  output logic [ADDR_W-1:0] ext_mem_r_addr_o,
  input  logic [DATA_W-1:0] ext_mem_r_data_i
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   ram_level_q, ram_level_d;
  logic              rd_pending_q, rd_pending_d;
  logic [1:0]        obuf_count_q, obuf_count_d;
  logic [DATA_W-1:0] obuf0_q, obuf0_d, obuf1_q, obuf1_d;

  logic       push, pop, rd_issue;
  logic [1:0] obuf_after_pop;
  logic [2:0] occ_next;

  // Gating with the reset keeps the RAM write port quiet while reset is held.
  assign s_ready_o = arst_n_i & (ram_level_q != DEPTH) & ~clear_i;
  assign push      = s_valid_i & s_ready_o;
  assign m_valid_o = (obuf_count_q != 2'd0);
  assign pop       = m_valid_o & m_ready_i;
  assign m_data_o  = obuf0_q;

  assign obuf_after_pop = obuf_count_q - {1'b0, pop};
  assign occ_next       = {1'b0, obuf_after_pop} + {2'b00, rd_pending_q};
  assign rd_issue       = (ram_level_q != '0) & (occ_next <= 3'd1) & ~clear_i;

  assign ext_mem_w_en_o   = push;
  assign ext_mem_w_addr_o = wr_ptr_q;
  assign ext_mem_w_data_o = s_data_i;
  assign ext_mem_r_en_o   = rd_issue;
  assign ext_mem_r_addr_o = rd_ptr_q;

  assign level_o = ram_level_q + {{ADDR_W{1'b0}}, rd_pending_q}
                 + {{(ADDR_W-1){1'b0}}, obuf_count_q};

  always_comb begin
    wr_ptr_d     = wr_ptr_q + ADDR_W'(push);
    rd_ptr_d     = rd_ptr_q + ADDR_W'(rd_issue);
    ram_level_d  = ram_level_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(rd_issue);
    rd_pending_d = rd_issue;
    obuf_count_d = occ_next[1:0];
    obuf0_d      = pop ? obuf1_q : obuf0_q;
    obuf1_d      = obuf1_q;
    // Returning RAM word lands in the first slot left free after this cycle's pop.
    if (rd_pending_q) begin
      if (obuf_after_pop == 2'd0) obuf0_d = ext_mem_r_data_i;
      else                        obuf1_d = ext_mem_r_data_i;
    end
    if (clear_i) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      ram_level_d  = '0;
      rd_pending_d = 1'b0;
      obuf_count_d = 2'd0;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ram_level_q  <= '0;
      rd_pending_q <= 1'b0;
      obuf_count_q <= 2'd0;
      obuf0_q      <= '0;
      obuf1_q      <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ram_level_q  <= ram_level_d;
      rd_pending_q <= rd_pending_d;
      obuf_count_q <= obuf_count_d;
      obuf0_q      <= obuf0_d;
      obuf1_q      <= obuf1_d;
    end
  end

endmodule

// File: tb/tb_iob_fifo_stream_ctrl.sv
// Bench for iob_fifo_stream_ctrl: RAM model, queue scoreboard, directed and random traffic.
module tb_iob_fifo_stream_ctrl;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int CAP = 2**AW + 2;

  logic          clk = 1'b0;
  logic          arst_n, clear, s_valid, s_ready, m_valid, m_ready;
  logic [DW-1:0] s_data, m_data, w_data, r_data;
  logic [AW:0]   level;
  logic          w_en, r_en;
  logic [AW-1:0] w_addr, r_addr;

  logic [DW-1:0] mem [2**AW];
  bit            written [2**AW];
  logic [DW-1:0] model_q [$];

  int checks = 0;
  int passed = 0;

  iob_fifo_stream_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk_i(clk), .arst_n_i(arst_n), .clear_i(clear),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data),
    .level_o(level),
    .ext_mem_w_en_o(w_en), .ext_mem_w_addr_o(w_addr), .ext_mem_w_data_o(w_data),
    .ext_mem_r_en_o(r_en), .ext_mem_r_addr_o(r_addr), .ext_mem_r_data_i(r_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (w_en) mem[w_addr] <= w_data;
    if (r_en) r_data <= mem[r_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 200 && level != 0; i++) step();
    chk(name, level, 0);
  endtask

  // Monitor: the queue holds every accepted, not yet consumed word in order.
  always @(negedge clk) begin
    if (!arst_n) begin
      model_q.delete();
      foreach (written[i]) written[i] = 1'b0;
    end else begin
      chk("level_vs_model", level, model_q.size());
      if (level > CAP) chk("level_max", level, CAP);
      if (model_q.size() == 0) chk("empty_no_valid", m_valid, 0);
      if (r_en) begin
        chk("read_of_written", written[r_addr], 1);
        written[r_addr] = 1'b0;
      end
      if (w_en) written[w_addr] = 1'b1;
      if (m_valid && m_ready) begin
        if (model_q.size() == 0) chk("pop_nonempty", 0, 1);
        else chk("data_order", m_data, model_q.pop_front());
      end
      if (s_valid && s_ready) model_q.push_back(s_data);
      if (clear) begin
        model_q.delete();
        foreach (written[i]) written[i] = 1'b0;
      end
    end
  end

  initial begin
    int acc;
    int pushes;
    int cyc;
    logic [DW-1:0] seq [3];
    arst_n = 1'b0; clear = 1'b0; s_valid = 1'b1; s_data = 32'hDEAD; m_ready = 1'b0;
    #12;
    chk("rst_level", level, 0);
    chk("rst_mvalid", m_valid, 0);
    chk("rst_wen", w_en, 0);
    chk("rst_ren", r_en, 0);
    s_valid = 1'b0;
    #11 arst_n = 1'b1;
    step();
    chk("rst_sready", s_ready, 1);

    // Three-word latency test
    seq[0] = 32'h11; seq[1] = 32'h22; seq[2] = 32'h33;
    m_ready = 1'b1;
    s_valid = 1'b1; s_data = seq[0]; step();
    s_data = seq[1]; step();
    s_data = seq[2]; chk("lat_not_early", m_valid, 0); step();
    s_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("lat_valid", m_valid, 1);
      chk("lat_data", m_data, seq[i]);
      step();
    end
    chk("lat_after", m_valid, 0);
    drain("lat_drain");

    // Capacity with consumer stalled
    m_ready = 1'b0; acc = 0;
    for (int i = 0; i < 30; i++) begin
      s_valid = 1'b1; s_data = 32'h100 + i;
      if (s_ready) acc++;
      step();
    end
    s_valid = 1'b0;
    chk("cap_accepted", acc, CAP);
    chk("cap_sready", s_ready, 0);
    chk("cap_level", level, CAP);
    m_ready = 1'b1;
    for (int i = 0; i < 10 && !s_ready; i++) step();
    chk("cap_sready_rise", s_ready, 1);
    drain("cap_drain");

    // Steady level 5 with simultaneous push/pop, pointers wrap
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin s_valid = 1'b1; s_data = 32'h500 + i; step(); end
    s_valid = 1'b0;
    repeat (5) step();
    chk("lvl5_fill", level, 5);
    s_valid = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      s_data = $urandom;
      if (level != 5) chk("lvl5_const", level, 5);
      step();
    end
    chk("lvl5_end", level, 5);
    drain("lvl5_drain");

    // Clear with a read in flight
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin s_valid = 1'b1; s_data = 32'hC0 + i; step(); end
    s_valid = 1'b0; clear = 1'b1; step();
    clear = 1'b0;
    chk("clr_mvalid", m_valid, 0);
    chk("clr_level", level, 0);
    repeat (3) step();
    chk("clr_no_stale", m_valid, 0);
    s_valid = 1'b1; s_data = 32'hAA; m_ready = 1'b1; step();
    s_valid = 1'b0;
    for (int i = 0; i < 10 && !m_valid; i++) step();
    chk("clr_first_valid", m_valid, 1);
    chk("clr_first_data", m_data, 32'hAA);
    drain("clr_drain");

    // Asynchronous reset mid-stream
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin s_valid = 1'b1; s_data = 32'hE0 + i; step(); end
    s_valid = 1'b0;
    #2 arst_n = 1'b0;
    #1;
    chk("arst_mvalid", m_valid, 0);
    chk("arst_level", level, 0);
    @(posedge clk); @(posedge clk);
    #3 arst_n = 1'b1;
    step();
    chk("arst_sready", s_ready, 1);
    m_ready = 1'b1; s_valid = 1'b1; s_data = 32'h5; step();
    s_valid = 1'b0; step();
    chk("arst_not_early", m_valid, 0); step();
    chk("arst_valid", m_valid, 1);
    chk("arst_data", m_data, 32'h5);
    drain("arst_drain");

    // Random traffic
    pushes = 0; cyc = 0;
    while (pushes < 10000 && cyc < 60000) begin
      s_valid = 1'($urandom_range(0, 1));
      m_ready = 1'($urandom_range(0, 1));
      s_data  = $urandom;
      if (s_valid && s_ready) pushes++;
      step();
      cyc++;
    end
    s_valid = 1'b0;
    chk("rand_words", pushes, 10000);
    drain("rand_drain");
    step();
    chk("final_queue", model_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
